// File: rtl/spi_slave_framed.sv
// SPI slave clocked by the serial clock: framed multi-word transfers, TX valid/ready
// with fill-word underrun, RX holding register with overrun, abort detect and word counter.
module spi_slave_framed #(
   parameter int                    DATA_WIDTH = 8,
   parameter bit                    MSB_FIRST  = 1'b1,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0,
   parameter int                    CNT_WIDTH  = 8
) (
   input  logic                  spi_clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ack,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  underrun,
   output logic                  overrun,
   output logic                  abort,
   input  logic                  clear_flags
);

   localparam int                   BCW      = $clog2(DATA_WIDTH);
   localparam logic [BCW-1:0]       LAST_BIT = BCW'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                  in_frame_q, in_frame_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic                  tx_loaded_q, tx_loaded_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
   logic                  underrun_q, underrun_d;
   logic                  overrun_q, overrun_d;
   logic                  abort_q, abort_d;

   logic [DATA_WIDTH-1:0] rx_sampled;
   logic [DATA_WIDTH-1:0] tx_shifted;
   logic [CNT_WIDTH-1:0]  cnt_base;
   logic                  word_done;

   assign word_done = ~cs & (bit_cnt_q == LAST_BIT);
   assign tx_ready  = (cs & ~tx_loaded_q) | word_done;
   assign miso      = cs ? 1'b0 : (MSB_FIRST ? tx_shift_q[DATA_WIDTH-1] : tx_shift_q[0]);

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign busy       = in_frame_q;
   assign word_count = word_count_q;
   assign underrun   = underrun_q;
   assign overrun    = overrun_q;
   assign abort      = abort_q;

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      in_frame_d   = in_frame_q;
      tx_shift_d   = tx_shift_q;
      tx_loaded_d  = tx_loaded_q;
      rx_shift_d   = rx_shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      word_count_d = word_count_q;
      underrun_d   = underrun_q;
      overrun_d    = overrun_q;
      abort_d      = abort_q;

      rx_sampled = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi}
                             : {mosi, rx_shift_q[DATA_WIDTH-1:1]};
      tx_shifted = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
      cnt_base   = in_frame_q ? word_count_q : '0;

      // Clear first so that any flag raised below at this same edge survives.
      if (clear_flags) begin
         underrun_d = 1'b0;
         overrun_d  = 1'b0;
         abort_d    = 1'b0;
      end

      if (cs) begin
         in_frame_d = 1'b0;
         if (bit_cnt_q != '0) begin
            abort_d     = 1'b1;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
            tx_loaded_d = 1'b0;
         end
         if (tx_valid && tx_ready) begin
            tx_shift_d  = tx_data;
            tx_loaded_d = 1'b1;
         end
      end else begin
         rx_shift_d   = rx_sampled;
         word_count_d = cnt_base;
         if (!in_frame_q) begin
            in_frame_d = 1'b1;
            if (!tx_loaded_q) underrun_d = 1'b1;
         end
         if (bit_cnt_q != LAST_BIT) begin
            tx_shift_d = tx_shifted;
            bit_cnt_d  = bit_cnt_q + BCW'(1);
         end else begin
            rx_data_d  = rx_sampled;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
            word_count_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_WIDTH'(1);
            bit_cnt_d    = '0;
            tx_loaded_d  = 1'b1;
            if (tx_valid) begin
               tx_shift_d = tx_data;
            end else begin
               tx_shift_d = FILL_WORD;
               underrun_d = 1'b1;
            end
         end
      end

      // A completing word always wins over an acknowledge at the same edge.
      if (rx_ack && !word_done) rx_valid_d = 1'b0;
   end

   always_ff @(posedge spi_clk) begin
      if (!reset) begin
         bit_cnt_q    <= '0;
         in_frame_q   <= 1'b0;
         tx_shift_q   <= '0;
         tx_loaded_q  <= 1'b0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         word_count_q <= '0;
         underrun_q   <= 1'b0;
         overrun_q    <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         in_frame_q   <= in_frame_d;
         tx_shift_q   <= tx_shift_d;
         tx_loaded_q  <= tx_loaded_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         word_count_q <= word_count_d;
         underrun_q   <= underrun_d;
         overrun_q    <= overrun_d;
         abort_q      <= abort_d;
      end
   end

endmodule

// File: tb/tb_spi_slave_framed.sv
// Bench for spi_slave_framed: an 8-bit MSB-first and a 16-bit LSB-first instance, a word-level
// reference model, and a monitor that checks every completed word against the expected queues.
module tb_spi_slave_framed;

   logic spi_clk = 1'b0;
   always #5 spi_clk = ~spi_clk;

   logic        reset, cs8, cs16, mosi, tx_valid, rx_ack, clear_flags;
   logic [15:0] tx_data;

   logic       miso8, tx_ready8, rx_valid8, busy8, under8, over8, abort8;
   logic [7:0] rx_data8, wc8;
   logic        miso16, tx_ready16, rx_valid16, busy16, under16, over16, abort16;
   logic [15:0] rx_data16;
   logic [7:0]  wc16;

   spi_slave_framed #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .FILL_WORD(8'h00), .CNT_WIDTH(8)) dut8 (
      .spi_clk(spi_clk), .reset(reset), .cs(cs8), .mosi(mosi), .miso(miso8),
      .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(tx_ready8),
      .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ack(rx_ack), .busy(busy8),
      .word_count(wc8), .underrun(under8), .overrun(over8), .abort(abort8),
      .clear_flags(clear_flags));

   spi_slave_framed #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .FILL_WORD(16'hBEEF), .CNT_WIDTH(8)) dut16 (
      .spi_clk(spi_clk), .reset(reset), .cs(cs16), .mosi(mosi), .miso(miso16),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready16),
      .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ack(rx_ack), .busy(busy16),
      .word_count(wc16), .underrun(under16), .overrun(over16), .abort(abort16),
      .clear_flags(clear_flags));

   // sel picks the instance under test; the other one sits idle with cs high.
   logic        sel;
   logic        d_cs, d_miso, d_tx_ready, d_rx_valid, d_busy, d_under, d_over, d_abort;
   logic [15:0] d_rx_data;
   logic [7:0]  d_wc;
   assign d_cs       = sel ? cs16 : cs8;
   assign d_miso     = sel ? miso16 : miso8;
   assign d_tx_ready = sel ? tx_ready16 : tx_ready8;
   assign d_rx_valid = sel ? rx_valid16 : rx_valid8;
   assign d_busy     = sel ? busy16 : busy8;
   assign d_under    = sel ? under16 : under8;
   assign d_over     = sel ? over16 : over8;
   assign d_abort    = sel ? abort16 : abort8;
   assign d_rx_data  = sel ? rx_data16 : {8'h00, rx_data8};
   assign d_wc       = sel ? wc16 : wc8;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] exp_rx_q[$];
   logic [15:0] exp_tx_q[$];
   bit          exp_chk_q[$];
   logic        acc_q[$];

   // Word-level reference model.
   int          m_bits, m_wc;
   bit          m_in_frame, m_loaded, m_tx_zero, m_rx_valid, m_under, m_over, m_abort;
   logic [15:0] m_next;

   function automatic int width();
      return sel ? 16 : 8;
   endfunction

   function automatic logic [15:0] wmask();
      return sel ? 16'hFFFF : 16'h00FF;
   endfunction

   function automatic logic [15:0] fill();
      return sel ? 16'hBEEF : 16'h0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits = 0; m_wc = 0; m_in_frame = 0; m_loaded = 0; m_tx_zero = 1;
      m_rx_valid = 0; m_under = 0; m_over = 0; m_abort = 0; m_next = '0;
   endtask

   task automatic model_edge(input logic c, input logic tv, input logic [15:0] td,
                             input logic ack, input logic clr);
      bit was_loaded, done;
      was_loaded = m_loaded;
      done = 0;
      if (!reset) begin
         model_reset();
         return;
      end
      if (clr) begin m_under = 0; m_over = 0; m_abort = 0; end
      if (c) begin
         m_in_frame = 0;
         if (m_bits != 0) begin m_abort = 1; m_bits = 0; m_loaded = 0; end
         if (tv && !was_loaded) begin m_next = td & wmask(); m_loaded = 1; m_tx_zero = 0; end
      end else begin
         if (!m_in_frame) begin
            m_in_frame = 1; m_wc = 0;
            if (!m_loaded) m_under = 1;
         end
         m_bits++;
         if (m_bits == width()) begin
            done = 1; m_bits = 0;
            if (m_wc < 255) m_wc++;
            if (m_rx_valid && !ack) m_over = 1;
            m_rx_valid = 1;
            if (tv) m_next = td & wmask();
            else begin m_next = fill(); m_under = 1; end
            m_loaded = 1; m_tx_zero = 0;
         end
      end
      if (ack && !done) m_rx_valid = 0;
   endtask

   // Inputs change 1 time unit after the rising edge and stay put until the next one.
   task automatic step(input logic c, input logic m, input logic tv, input logic [15:0] td,
                       input logic ack, input logic clr);
      if (sel) cs16 = c; else cs8 = c;
      mosi = m; tx_valid = tv; tx_data = td; rx_ack = ack; clear_flags = clr;
      @(posedge spi_clk);
      model_edge(c, tv, td, ack, clr);
      #1;
   endtask

   task automatic idle(input logic tv, input logic [15:0] td, input logic ack, input logic clr);
      step(1'b1, 1'b0, tv, td, ack, clr);
   endtask

   // ack_mode: 0 none, 1 acknowledge at the first bit edge, 2 at the completing edge.
   task automatic xfer_word(input logic [15:0] word, input logic tv, input logic [15:0] td,
                            input int ack_mode);
      logic [15:0] wv;
      int w;
      logic b, ack;
      w  = width();
      wv = word & wmask();
      exp_rx_q.push_back(wv);
      if (m_in_frame || m_loaded) begin
         exp_tx_q.push_back(m_next); exp_chk_q.push_back(1'b1);
      end else begin
         exp_tx_q.push_back(16'h0000); exp_chk_q.push_back(m_tx_zero);
      end
      for (int i = 0; i < w; i++) begin
         b   = sel ? wv[i] : wv[w-1-i];
         ack = (ack_mode == 1 && i == 0) || (ack_mode == 2 && i == w - 1);
         step(1'b0, b, tv, td, ack, 1'b0);
      end
   endtask

   task automatic partial(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_underrun"}, 32'(d_under), 32'(m_under));
      check({tag, "_overrun"}, 32'(d_over), 32'(m_over));
      check({tag, "_abort"}, 32'(d_abort), 32'(m_abort));
      check({tag, "_rx_valid"}, 32'(d_rx_valid), 32'(m_rx_valid));
      check({tag, "_word_count"}, 32'(d_wc), 32'(m_wc));
      check({tag, "_busy"}, 32'(d_busy), 32'(m_in_frame));
      check({tag, "_miso_idle"}, 32'(d_miso), 32'(0));
      check({tag, "_tx_ready_idle"}, 32'(d_tx_ready), 32'(!m_loaded));
   endtask

   task automatic random_frame();
      int nw;
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++)
         xfer_word(16'($urandom), $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) partial($urandom_range(1, width() - 1));
      idle($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      check_state("rand");
   endtask

   // Monitor: a word_count step to a nonzero value marks a completed word.
   logic [7:0]  prev_wc = '0;
   logic [15:0] mon_exp_rx, mon_exp_tx, mon_got;
   bit          mon_chk;
   always @(negedge spi_clk) begin
      if (d_wc != prev_wc && d_wc != 8'h00) begin
         if (exp_rx_q.size() == 0) begin
            check("unexpected_word", 32'(d_rx_data), 32'hFFFF_FFFF);
         end else begin
            mon_exp_rx = exp_rx_q.pop_front();
            mon_exp_tx = exp_tx_q.pop_front();
            mon_chk    = exp_chk_q.pop_front();
            check("rx_data", 32'(d_rx_data), 32'(mon_exp_rx));
            if (mon_chk) begin
               mon_got = '0;
               for (int i = 0; i < acc_q.size() && i < 16; i++) begin
                  if (sel) mon_got[i] = acc_q[i];
                  else     mon_got = {mon_got[14:0], acc_q[i]};
               end
               check("miso_bits", 32'(acc_q.size()), 32'(width()));
               check("miso_word", 32'(mon_got), 32'(mon_exp_tx));
            end
         end
         acc_q.delete();
      end
      prev_wc = d_wc;
      if (d_cs) acc_q.delete();
      else      acc_q.push_back(d_miso);
   end

   initial begin
      sel = 0; cs8 = 1; cs16 = 1; mosi = 0; tx_data = '0; tx_valid = 0;
      rx_ack = 0; clear_flags = 0; reset = 0;
      model_reset();
      idle(0, 0, 0, 0);
      idle(0, 0, 0, 0);
      reset = 1;

      // 8-bit MSB-first instance.
      idle(0, 0, 0, 0);
      idle(0, 0, 0, 0);
      check_state("reset");
      check("reset_rx_data", 32'(d_rx_data), 32'h0);
      check("reset_tx_ready", 32'(d_tx_ready), 32'h1);
      idle(1, 16'h00A5, 0, 0);
      check("tx_ready_after_load", 32'(d_tx_ready), 32'h0);

      xfer_word(16'h3C, 1, 16'h11, 0);
      idle(0, 0, 0, 0);
      check_state("first_word");

      xfer_word(16'h11, 1, 16'h22, 1);
      xfer_word(16'h22, 0, 16'h00, 1);
      xfer_word(16'h33, 1, 16'h77, 1);
      idle(0, 0, 0, 0);
      check_state("three_word");
      check("three_word_underrun", 32'(d_under), 32'h1);
      check("three_word_count", 32'(d_wc), 32'h3);
      idle(0, 0, 0, 1);
      check_state("clear_underrun");

      xfer_word(16'($urandom), 1, 16'($urandom), 0);
      xfer_word(16'($urandom), 1, 16'($urandom), 0);
      idle(0, 0, 0, 0);
      check_state("overrun");
      check("overrun_set", 32'(d_over), 32'h1);
      idle(0, 0, 0, 1);
      xfer_word(16'($urandom), 1, 16'($urandom), 2);
      idle(0, 0, 0, 0);
      check_state("ack_at_completion");
      check("ack_at_completion_valid", 32'(d_rx_valid), 32'h1);

      partial(5);
      idle(0, 0, 0, 0);
      check_state("abort");
      check("abort_set", 32'(d_abort), 32'h1);
      idle(1, 16'($urandom), 0, 0);
      xfer_word(16'h5A, 1, 16'($urandom), 1);
      idle(0, 0, 0, 0);
      check_state("after_abort");
      idle(0, 0, 0, 1);
      check_state("clear_abort");

      repeat (25) random_frame();
      idle(0, 0, 0, 0);
      check("queue_empty_8", 32'(exp_rx_q.size()), 32'h0);

      // 16-bit LSB-first instance.
      reset = 0;
      sel = 1;
      idle(0, 0, 0, 0);
      reset = 1;
      idle(0, 0, 0, 0);
      check_state("reset16");
      idle(1, 16'h8001, 0, 0);
      xfer_word(16'h1234, 1, 16'($urandom), 0);
      idle(0, 0, 0, 0);
      check_state("lsb_word");
      check("lsb_rx_data", 32'(d_rx_data), 32'h1234);

      repeat (15) random_frame();

      partial(7);
      reset = 0;
      idle(0, 0, 0, 0);
      reset = 1;
      check_state("mid_word_reset");
      check("mid_word_reset_rx_data", 32'(d_rx_data), 32'h0);
      cs16 = 0;
      #1;
      check("reset_tx_shift_miso", 32'(d_miso), 32'h0);
      cs16 = 1;
      idle(0, 0, 0, 0);
      check("queue_empty_16", 32'(exp_rx_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
